// File: rtl/spi_reg_pkg.sv
// Shared constants, frame layout and FSM encoding for the SPI register peripheral.
package spi_reg_pkg;

    localparam int unsigned FRAME_BITS  = 16;
    localparam int unsigned DATA_BITS   = 8;
    localparam int unsigned ADDR_BITS   = 7;
    localparam int unsigned NUM_REGS    = 5;
    localparam int unsigned CNT_BITS    = 5;
    localparam int unsigned CNT_OVERRUN = 17;

    localparam logic [ADDR_BITS-1:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [ADDR_BITS-1:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [ADDR_BITS-1:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [ADDR_BITS-1:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [ADDR_BITS-1:0] ADDR_DUTY      = 7'h04;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_e;

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SHIFT  = SHIFT;
    localparam logic [1:0] ST_COMMIT = COMMIT;

    // One received frame, MSB first on the wire.
    typedef struct packed {
        logic                 wr;
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] data;
    } frame_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin plus rise/fall detection
// against one extra delayed flop.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_c = sync_q[SYNC_STAGES-1] & ~dly_q;
    assign fall_c = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/spi_reg_peripheral.sv
// Mode-0 SPI write-mostly peripheral feeding a five-entry configuration register bank.
// Optional register readback on cipo is enabled by defining SPI_READBACK_EN.
module spi_reg_peripheral
    import spi_reg_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_pulse
);

    localparam logic [ADDR_BITS-1:0] MAX_ADDR_A = ADDR_BITS'(MAX_ADDR);
    localparam logic [ADDR_BITS-1:0] LAST_REG_A = ADDR_BITS'(NUM_REGS - 1);
    localparam logic [CNT_BITS-1:0]  CNT_FULL   = CNT_BITS'(FRAME_BITS);
    localparam logic [CNT_BITS-1:0]  CNT_SAT    = CNT_BITS'(CNT_OVERRUN);

    logic                   sclk_rise_c;
    logic                   sclk_fall_c;
    logic                   ncs_rise_c;
    logic                   ncs_fall_c;
    logic [SYNC_STAGES-1:0] copi_sync_q;
    logic                   copi_s;

    logic [1:0]             state_q, state_d;
    logic [CNT_BITS-1:0]    cnt_q, cnt_d;
    logic [FRAME_BITS-1:0]  shift_q, shift_d;
    logic                   commit_c;
    frame_t                 frame_c;

    logic [DATA_BITS-1:0]   regs_q [NUM_REGS];
    logic                   wr_pulse_q;

    function automatic logic addr_ok(input logic [ADDR_BITS-1:0] a);
        return (a <= MAX_ADDR_A) && (a <= LAST_REG_A);
    endfunction

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk    (clk),
        .rst    (rst),
        .d      (sclk),
        .rise_c (sclk_rise_c),
        .fall_c (sclk_fall_c)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ncs_sync (
        .clk    (clk),
        .rst    (rst),
        .d      (ncs),
        .rise_c (ncs_rise_c),
        .fall_c (ncs_fall_c)
    );

    // copi only needs its level, so it gets a bare synchronizer.
    always_ff @(posedge clk) begin
        if (rst) begin
            copi_sync_q <= '0;
        end else begin
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
        end
    end

    assign copi_s  = copi_sync_q[SYNC_STAGES-1];
    assign frame_c = frame_t'(shift_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        commit_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                shift_d = '0;
                if (ncs_fall_c) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // A fresh ncs fall mid-frame is treated as a restart.
                if (ncs_fall_c) begin
                    cnt_d   = '0;
                    shift_d = '0;
                end else if (ncs_rise_c) begin
                    state_d = ST_COMMIT;
                end else if (sclk_rise_c) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], copi_s};
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + CNT_BITS'(1);
                    end
                end
            end
            ST_COMMIT: begin
                state_d  = ST_IDLE;
                commit_c = (cnt_q == CNT_FULL) && frame_c.wr && addr_ok(frame_c.addr);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
            wr_pulse_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (commit_c && (frame_c.addr == ADDR_BITS'(i))) begin
                    regs_q[i] <= frame_c.data;
                end
            end
            wr_pulse_q <= commit_c;
        end
    end

    assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_LO[2:0]];
    assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_HI[2:0]];
    assign en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_LO[2:0]];
    assign en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_HI[2:0]];
    assign pwm_duty_cycle  = regs_q[ADDR_DUTY[2:0]];
    assign wr_pulse        = wr_pulse_q;

`ifdef SPI_READBACK_EN
    logic [DATA_BITS-1:0] tx_q;
    logic [DATA_BITS-1:0] rd_data_c;

    // After 8 bits shift_d holds {R/W, address} in its low byte.
    always_comb begin
        rd_data_c = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if ((shift_d[ADDR_BITS-1:0] == ADDR_BITS'(i)) && addr_ok(shift_d[ADDR_BITS-1:0])) begin
                rd_data_c = regs_q[i];
            end
        end
    end

    // The fall right after the 8th rise keeps the MSB; later falls shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q <= '0;
        end else if (state_q == ST_IDLE) begin
            tx_q <= '0;
        end else if ((state_q == ST_SHIFT) && (cnt_q == CNT_BITS'(7)) && (cnt_d == CNT_BITS'(8))) begin
            tx_q <= shift_d[ADDR_BITS] ? '0 : rd_data_c;
        end else if ((state_q == ST_SHIFT) && sclk_fall_c && (cnt_q >= CNT_BITS'(9))) begin
            tx_q <= {tx_q[DATA_BITS-2:0], 1'b0};
        end
    end

    assign cipo = tx_q[DATA_BITS-1];
`else
    assign cipo = 1'b0;
`endif

endmodule

// File: doc/spi_reg_peripheral.md
Name: spi_reg_peripheral

Overview:
- SPI peripheral (mode 0, write-mostly) that receives 16-bit frames from an external controller and updates a five-entry configuration register bank.
- Sits directly upstream of the PWM/output-enable stage inside the top-level user project; its register outputs are that stage's only configuration inputs.
- All SPI pins are asynchronous to clk. They are synchronized and edge-detected in the clk domain, so SCLK must be ≤ clk/4.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of each input synchronizer (legal ≥2)
- MAX_ADDR, 4, highest writable register address; addresses above it are discarded

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset (top level drives it with ~rst_n)
- sclk  input  1  SPI clock, async
- copi  input  1  SPI controller-out data, async
- ncs  input  1  SPI chip select, active low, async
- cipo  output  1  SPI peripheral-out data (0 unless SPI_READBACK_EN)
- en_reg_out_7_0  output  8  register 0x00
- en_reg_out_15_8  output  8  register 0x01
- en_reg_pwm_7_0  output  8  register 0x02
- en_reg_pwm_15_8  output  8  register 0x03
- pwm_duty_cycle  output  8  register 0x04
- wr_pulse  output  1  one-cycle strobe on each committed write

Behaviour:
- Reset values: all registers 0x00, wr_pulse 0, cipo 0, FSM IDLE, bit counter 0.
- Synchronizers: sclk, copi and ncs each pass through SYNC_STAGES flops. Rising and falling edges of sclk_s and ncs_s are detected against one more delayed flop.
- Frame format, MSB first: bit15 = R/W (1 = write), bits14:8 = address[6:0], bits7:0 = data.
- COPI is sampled on the sclk_s rising edge.
- FSM IDLE:
  - ncs_s falling edge -> SHIFT.
  - Clear shift register and counter.
  - SCLK edges while in IDLE are ignored.
- FSM SHIFT:
  - Each sclk_s rising edge shifts copi_s in. Counter saturates at 17 (17 means overrun).
  - ncs_s rising edge -> COMMIT.
- FSM COMMIT, exactly one cycle:
  - Write is committed only if counter == 16, bit15 == 1 and address ≤ MAX_ADDR.
  - On commit: the register takes the data on the next clk edge and wr_pulse = 1 for that one cycle.
  - Otherwise the frame is discarded silently.
  - Always returns to IDLE.
- Latency: register visible 1 clk after the COMMIT cycle, i.e. SYNC_STAGES+2 clk after the physical ncs rise.
- Short frame (<16 bits), long frame (>16 bits), read frame (bit15 = 0) or out-of-range address: no register change, no wr_pulse.
- ncs_s falling edge seen while in SHIFT (glitch) restarts the frame: counter and shift register cleared.
- Reset mid-frame: everything returns to its reset value.
  - Because an ncs falling edge is required to leave IDLE, the remainder of the interrupted frame is ignored.
  - Decoding resumes only with the next ncs falling edge.
- Registers hold their value indefinitely. There is no auto-clear.

Optional Feature:
- Macro: SPI_READBACK_EN.
- Defined:
  - For a read frame, after the 8th rising sclk edge the addressed register is loaded into an output shift register (0x00 if address > MAX_ADDR).
  - cipo drives its MSB and shifts on each sclk_s falling edge, for 8 bits.
  - cipo returns to 0 in IDLE.
  - The read never changes registers or pulses wr_pulse.
- Undefined: cipo is tied to 0 and read frames are simply discarded.

Decomposition:
- Package spi_reg_pkg:
  - FRAME_BITS = 16.
  - Address constants ADDR_EN_OUT_LO=0x00, ADDR_EN_OUT_HI=0x01, ADDR_EN_PWM_LO=0x02, ADDR_EN_PWM_HI=0x03, ADDR_DUTY=0x04.
  - FSM state enum {IDLE, SHIFT, COMMIT}.
- Sub-module sync_edge:
  - Parameterized synchronizer plus rise/fall detector.
  - Instantiated for sclk and ncs; copi uses the synchronizer only.

Test Plan:
- Write frame 0x80F0 (addr 0x00, data 0xF0), SCLK = clk/8 -> en_reg_out_7_0 = 0xF0; wr_pulse high exactly one cycle; other registers stay 0x00.
- Write frames 0x8480 then 0x8355 -> pwm_duty_cycle = 0x80, en_reg_pwm_15_8 = 0x55; two wr_pulses in total.
- Write frame 0x85AA (addr 0x05) and read frame 0x00FF -> all registers unchanged, no wr_pulse.
- 15-bit frame and 17-bit frame, both with write to addr 0x01 data 0x3C -> en_reg_out_15_8 stays 0x00, no wr_pulse.
- Assert rst after bit 8 of frame 0x8211, keep ncs low for the remaining bits, then send a fresh frame 0x8222 -> en_reg_pwm_7_0 = 0x22 (0x11 never appears).
- (SPI_READBACK_EN) Write 0x8499, then send read frame 0x0400 -> cipo shifts out 1,0,0,1,1,0,0,1 on bits 7..0 and pwm_duty_cycle stays 0x99.
